// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: holds one fetched instruction until downstream accepts it.
interface fetch_unit_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (output if_valid, output if_pc, output if_instr, input if_ready);
  modport slave  (input if_valid, input if_pc, input if_instr, output if_ready);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-entry output register, RUN/HALT control.
// Walks a combinational instruction ROM and halts when the PC runs past its end.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic [31:0]         rom_addr,
  input  logic [31:0]         rom_instr,
  fetch_unit_if.master        fo,
  output logic                halted,
  output logic                misalign_err,
  output logic [31:0]         fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN:0] ROM_BYTES = 33'(ROM_WORDS) << 2;

  typedef enum logic [0:0] {RUN, HALT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [XLEN-1:0]   if_instr_q, if_instr_d;
  logic [XLEN-1:0]   count_q, count_d;
  logic              misalign_q, misalign_d;
  logic              fetch_slot;
  logic              in_range;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state: redirect beats everything; otherwise fetch, halt, or drain on accept
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    in_range   = ({1'b0, pc_q} < ROM_BYTES);
    fetch_slot = (state_q == RUN) && !stall && !redirect_valid && (!valid_q || fo.if_ready);

    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      state_d = RUN;
      if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (fetch_slot) begin
      if (in_range) begin
        if_instr_d = rom_instr;
        if_pc_d    = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_q + 32'd4;
        count_d    = count_q + 32'd1;
      end else begin
        state_d = HALT;
        valid_d = 1'b0;
      end
    end else if (fo.if_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rom_addr     = pc_q;
  assign fo.if_valid  = valid_q;
  assign fo.if_pc     = if_pc_q;
  assign fo.if_instr  = if_instr_q;
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit with a combinational ROM model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int tests;
  int fails;

  fetch_unit_if fif ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .ROM_WORDS(256)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .fo             (fif),
    .halted         (halted),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0030_8113;
    if (a == 32'h4) return 32'h0041_0193;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign rom_instr = rom_fn(rom_addr);

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] erom;
    logic        eh;
    logic        em;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] erom, input logic eh, input logic em,
                              input logic [31:0] ecnt);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
    v.epc = epc; v.erom = erom; v.eh = eh; v.em = em; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " if_valid"}, 32'(fif.if_valid), 32'h0);
    check({tag, " if_pc"}, fif.if_pc, 32'h0);
    check({tag, " if_instr"}, fif.if_instr, 32'h0);
    check({tag, " rom_addr"}, rom_addr, 32'h0);
    check({tag, " fetch_count"}, fetch_count, 32'h0);
    check({tag, " halted"}, 32'(halted), 32'h0);
    check({tag, " misalign_err"}, 32'(misalign_err), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fif.if_ready = 1'b1;

    #1;
    check_reset_state("por");
    step();
    step();
    check_reset_state("rst_held");
    rst_n = 1'b1;

    //       st  rv   rpc         rdy ev  epc         erom        eh  em  cnt
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h0,     32'h4,     0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h4,     32'h8,     0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h8,     32'hC,     0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h8,     32'hC,     0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h8,     32'hC,     0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h8,     32'hC,     0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'hC,     32'h10,    0, 0, 4));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 32'hC,     32'h10,    0, 0, 4));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 32'hC,     32'h10,    0, 0, 4));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h10,    32'h14,    0, 0, 5));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h10,    32'h14,    0, 0, 5));
    vecs.push_back(mk(0, 1, 32'h26,    0, 0, 32'h10,    32'h24,    0, 1, 5));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h24,    32'h28,    0, 1, 6));
    vecs.push_back(mk(0, 1, 32'h3FC,   1, 0, 32'h24,    32'h3FC,   0, 1, 6));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h3FC,   32'h400,   0, 1, 7));
    vecs.push_back(mk(0, 0, 32'h0,     0, 1, 32'h3FC,   32'h400,   0, 1, 7));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h3FC,   32'h400,   1, 1, 7));
    vecs.push_back(mk(0, 0, 32'h0,     1, 0, 32'h3FC,   32'h400,   1, 1, 7));
    vecs.push_back(mk(0, 1, 32'h0,     1, 0, 32'h3FC,   32'h0,     0, 1, 7));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h0,     32'h4,     0, 1, 8));
    vecs.push_back(mk(1, 1, 32'h100,   1, 0, 32'h0,     32'h100,   0, 1, 8));
    vecs.push_back(mk(1, 0, 32'h0,     1, 0, 32'h0,     32'h100,   0, 1, 8));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h100,   32'h104,   0, 1, 9));
    vecs.push_back(mk(0, 1, 32'h28,    1, 0, 32'h100,   32'h28,    0, 1, 9));
    vecs.push_back(mk(0, 0, 32'h0,     1, 1, 32'h28,    32'h2C,    0, 1, 10));

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      stall          = vecs[i].st;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      fif.if_ready   = vecs[i].rdy;
      step();
      t = $sformatf("v%0d", i);
      check({t, " if_valid"}, 32'(fif.if_valid), 32'(vecs[i].ev));
      check({t, " if_pc"}, fif.if_pc, vecs[i].epc);
      check({t, " if_instr"}, fif.if_instr, rom_fn(vecs[i].epc));
      check({t, " rom_addr"}, rom_addr, vecs[i].erom);
      check({t, " halted"}, 32'(halted), 32'(vecs[i].eh));
      check({t, " misalign_err"}, 32'(misalign_err), 32'(vecs[i].em));
      check({t, " fetch_count"}, fetch_count, vecs[i].ecnt);
    end

    // Asynchronous reset mid-stream with PC=40 held in the output register
    stall = 1'b0;
    redirect_valid = 1'b0;
    fif.if_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    step();
    check_reset_state("async_rst_edge");
    rst_n = 1'b1;
    step();
    check("restart if_valid", 32'(fif.if_valid), 32'h1);
    check("restart if_pc", fif.if_pc, 32'h0);
    check("restart if_instr", fif.if_instr, 32'h0030_8113);
    check("restart fetch_count", fetch_count, 32'h1);
    check("restart rom_addr", rom_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter ROM_WORDS, default 256, the instruction ROM depth in 32-bit words.
REQ-003 SHALL provide port clk  input  1  rising-edge clock.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port stall  input  1  suppress new fetch this cycle.
REQ-006 SHALL provide port redirect_valid  input  1  load a new PC and flush the output.
REQ-007 SHALL provide port redirect_pc  input  32  target byte address for a redirect.
REQ-008 SHALL provide port rom_addr  output  32  byte address to the instruction ROM, combinational from the PC register.
REQ-009 SHALL provide port rom_instr  input  32  instruction word returned combinationally by the ROM for rom_addr.
REQ-010 SHALL provide port if_valid  output  1  if_pc/if_instr hold a valid fetched instruction.
REQ-011 SHALL provide port if_ready  input  1  downstream accepts the current if_* contents.
REQ-012 SHALL provide port if_pc  output  32  byte address of the held instruction.
REQ-013 SHALL provide port if_instr  output  32  held instruction word.
REQ-014 SHALL provide port halted  output  1  high while in HALT.
REQ-015 SHALL provide port misalign_err  output  1  sticky flag for a redirect_pc with [1:0] != 0.
REQ-016 SHALL provide port fetch_count  output  32  count of instructions loaded into the output register.

Function
REQ-017 SHALL implement states RUN and HALT in a registered FSM; rom_addr SHALL equal the PC register in every state.
REQ-018 SHALL define a fetch slot as: state RUN, stall low, redirect_valid low, and (if_valid low or if_ready high).
REQ-019 SHALL, on a fetch slot with PC < 4*ROM_WORDS, load if_instr<=rom_instr, if_pc<=PC, if_valid<=1, PC<=PC+4 (mod 2^32), fetch_count<=fetch_count+1 (wraps at 2^32); latency PC to if_valid is one clock.
REQ-020 SHALL, on a fetch slot with PC >= 4*ROM_WORDS, enter HALT, set if_valid<=0, and leave PC and fetch_count unchanged.
REQ-021 SHALL hold PC, if_pc, if_instr and if_valid unchanged while if_valid=1 and if_ready=0 (backpressure); the ROM value SHALL NOT be sampled.
REQ-022 SHALL, when if_ready=1 and no fetch slot occurs (stall high or state HALT), clear if_valid<=0 at the next edge.
REQ-023 SHALL give redirect_valid priority over stall, backpressure and HALT: PC<={redirect_pc[31:2],2'b00}, if_valid<=0, state<=RUN; no fetch occurs in that cycle.
REQ-024 SHALL set misalign_err<=1 on a redirect with redirect_pc[1:0] != 0; it SHALL stay 1 until reset.
REQ-025 SHALL drive halted=1 exactly when state is HALT; HALT SHALL be left only by redirect or reset.
REQ-026 SHALL keep all outputs free of combinational paths from if_ready, stall or redirect inputs.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously), force PC=RESET_PC, state=RUN, if_valid=0, if_pc=0, if_instr=0, fetch_count=0, misalign_err=0, halted=0.
REQ-028 SHALL, on reset asserted mid-operation, discard any held instruction and restart fetching from RESET_PC at the first edge after rst_n rises.

Verification
REQ-029 Reset release, if_ready=1, stall=0 -> cycle 1 if_pc=0 if_instr=32'h00308113; cycle 2 if_pc=4 if_instr=32'h00410193; fetch_count=2.
REQ-030 if_valid=1 with if_pc=8, if_ready=0 for 3 cycles -> if_pc/if_instr/rom_addr constant; if_ready=1 -> next edge if_pc=12.
REQ-031 stall=1 with if_ready=1 for 2 cycles at PC=16 -> if_valid=0, fetch_count unchanged; stall=0 -> if_pc=16.
REQ-032 redirect_valid=1 with redirect_pc=32'h0000_0026 during backpressure -> next edge if_valid=0, rom_addr=32'h24, misalign_err=1; following edge if_pc=32'h24.
REQ-033 redirect to 32'h3FC with ROM_WORDS=256 -> one fetch (if_pc=32'h3FC), then halted=1, if_valid=0 once accepted; redirect to 0 -> halted=0, fetching resumes at 0.
REQ-034 rst_n=0 pulsed mid-stream at PC=40 -> outputs clear immediately without waiting for clk; after release if_pc=0 and fetch_count=1.
